change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
//   Payout end of the vending machine's change path. Accepts a change amount,
//   then drives a two-denomination coin hopper one coin at a time.
//   Each coin uses an eject/ack handshake guarded by a timeout.
//   Tracks hopper inventory and reports completion, shortfall and jam.
//   Sits between vending_machine (requester) and the hopper driver pins.
// PARAMETERS
//   AMT_W    4   width of change amount, in base coin units
//   INV_W    6   width of each inventory counter
//   LG_VAL   2   value of the large coin in base units (small coin = 1)
//   TIMEOUT  16  cycles allowed in WAIT_ACK before declaring a jam
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous reset, active-low
//   req_valid  in   1      change request valid
//   req_amt    in   AMT_W  change to pay; sampled when req_valid & req_ready
//   req_ready  out  1      1 only in IDLE with refill=0
//   refill     in   1      load inventory this cycle; honoured only in IDLE
//   refill_lg  in   INV_W  large coins added on refill
//   refill_sm  in   INV_W  small coins added on refill
//   eject_lg   out  1      one-cycle pulse: eject one large coin
//   eject_sm   out  1      one-cycle pulse: eject one small coin
//   hopper_ack in   1      coin-exit sensor pulse from hopper
//   busy       out  1      1 in any state other than IDLE
//   done       out  1      one-cycle pulse at end of a request
//   short      out  1      valid with done: unpaid amount is nonzero
//   unpaid     out  AMT_W  remaining amount; meaningful when done=1
//   jam        out  1      sticky; clears only on reset
//   inv_lg     out  INV_W  current large-coin inventory
//   inv_sm     out  INV_W  current small-coin inventory
// BEHAVIOUR
//   Reset (reset=0, async):
//     - state=IDLE; all outputs 0 except req_ready=1.
//     - inventories, remaining and timer cleared.
//     - Takes effect mid-transaction; any eject pulse drops immediately.
//   FSM states: IDLE, SELECT, EJECT, WAIT_ACK, DONE, JAM.
//   IDLE
//     - refill=1: inv += refill value, saturating at 2^INV_W-1; req_ready=0.
//     - Request handshake: remaining<=req_amt; go DONE if req_amt==0, else SELECT.
//   SELECT
//     - remaining>=LG_VAL & inv_lg>0: coin=LG, go EJECT.
//     - else remaining>=1 & inv_sm>0: coin=SM, go EJECT.
//     - else go DONE.
//   EJECT
//     - Exactly one cycle; eject_lg or eject_sm high per coin.
//     - timer<=0; go WAIT_ACK.
//   WAIT_ACK
//     - hopper_ack: remaining -= coin value, matching inv -= 1, go SELECT.
//     - Otherwise timer++; at timer==TIMEOUT-1 go JAM.
//     - Ack in the same cycle as expiry wins (no jam).
//   DONE
//     - done=1 for one cycle; short=(remaining!=0); unpaid=remaining.
//     - Go IDLE.
//   JAM
//     - jam=1, busy=1, req_ready=0; no ejects. Exit only via reset.
//   Other rules
//     - hopper_ack outside WAIT_ACK is ignored; inventory unchanged.
//     - Outputs decode registered state; no combinational path from inputs
//       to eject_* or done.
//     - Latency: accept at edge k; first eject pulse in cycle k+2.
//     - Each coin costs 3 cycles plus the ack delay.
//     - remaining never underflows: large coin chosen only if remaining>=LG_VAL.
// STRUCTURE
//   Shared header vend_defs.vh:
//     - FSM state encodings.
//     - Coin-value constants, shared with vending_machine.
//   Sub-module hopper_timer: clear/enable counter with an expired flag at TIMEOUT-1.
//   Everything else lives in this module.
// TESTING
//   1 Reset: hold reset=0 10 cycles -> outputs 0, req_ready=1, inv_lg=inv_sm=0.
//   2 Normal payout: refill lg=3 sm=3, req_amt=5, ack 2 cycles after each eject
//     -> pulses lg, lg, sm; done with short=0; inv_lg=1, inv_sm=2.
//   3 Shortfall: refill lg=0 sm=2, req_amt=3 -> two sm pulses;
//     done with short=1, unpaid=1; inv_sm=0.
//   4 Jam: req_amt=1, sm=1, ack never sent -> jam=1 TIMEOUT cycles after the
//     eject pulse; req_ready stays 0 until reset.
//   5 Zero request and refill contention:
//     - req_amt=0 -> done 1 cycle after accept; no eject.
//     - refill=1 with req_valid=1 -> req_ready=0; request taken next cycle.
//   6 Reset mid-operation: reset=0 during WAIT_ACK -> eject_* and busy low at
//     once; after release, late hopper_ack is ignored and inventory stays 0.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change payout path: FSM state encoding,
// coin selector and coin-value constants.
package change_dispenser_pkg;

  // Payout FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_EJECT    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_JAM      = 3'd5
  } state_e;

  // Which hopper chute the current coin comes from.
  typedef enum logic {
    COIN_SM = 1'b0,
    COIN_LG = 1'b1
  } coin_e;

  // Coin values in base units; the small coin is the base unit.
  localparam int unsigned SM_VAL         = 1;
  localparam int unsigned LG_VAL_DEFAULT = 2;

endpackage

// File: rtl/change_dispenser_hopper_timer.sv
// Ack timeout counter: cleared when a coin is ejected, counts while the
// hopper has not yet acknowledged, flags expiry on its last allowed cycle.
module hopper_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a change amount and pays it out greedily from a
// two-denomination hopper, one coin per eject/ack handshake, tracking the
// hopper inventory and reporting completion, shortfall and jams.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned AMT_W   = 4,
  parameter int unsigned INV_W   = 6,
  parameter int unsigned LG_VAL  = LG_VAL_DEFAULT,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  input  logic             refill,
  input  logic [INV_W-1:0] refill_lg,
  input  logic [INV_W-1:0] refill_sm,
  output logic             eject_lg,
  output logic             eject_sm,
  input  logic             hopper_ack,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] unpaid,
  output logic             jam,
  output logic [INV_W-1:0] inv_lg,
  output logic [INV_W-1:0] inv_sm
);

  localparam int unsigned      TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AMT_W-1:0] LG_AMT = AMT_W'(LG_VAL);
  localparam logic [AMT_W-1:0] SM_AMT = AMT_W'(SM_VAL);

  state_e           state_q, state_d;
  coin_e            coin_q, coin_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [INV_W-1:0] inv_lg_q, inv_lg_d;
  logic [INV_W-1:0] inv_sm_q, inv_sm_d;

  logic             tmr_clr, tmr_en, tmr_expired;

  // Refill sums carry one extra bit so overflow can saturate at all-ones.
  logic [INV_W:0]   lg_sum, sm_sum;
  assign lg_sum = {1'b0, inv_lg_q} + {1'b0, refill_lg};
  assign sm_sum = {1'b0, inv_sm_q} + {1'b0, refill_sm};

  hopper_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Next-state, coin choice, remaining amount and inventory updates.
  // NOTE: every signal written here gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    coin_d   = coin_q;
    rem_d    = rem_q;
    inv_lg_d = inv_lg_q;
    inv_sm_d = inv_sm_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (refill) begin
          // Refill blocks the request handshake for this cycle.
          inv_lg_d = lg_sum[INV_W] ? '1 : lg_sum[INV_W-1:0];
          inv_sm_d = sm_sum[INV_W] ? '1 : sm_sum[INV_W-1:0];
        end else if (req_valid) begin
          rem_d   = req_amt;
          state_d = (req_amt == '0) ? ST_DONE : ST_SELECT;
        end
      end

      ST_SELECT: begin
        // Large coin first, but only when it cannot overpay.
        if ((rem_q >= LG_AMT) && (inv_lg_q != '0)) begin
          coin_d  = COIN_LG;
          state_d = ST_EJECT;
        end else if ((rem_q != '0) && (inv_sm_q != '0)) begin
          coin_d  = COIN_SM;
          state_d = ST_EJECT;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_EJECT: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        // An ack on the expiry cycle still counts as a delivered coin.
        if (hopper_ack) begin
          if (coin_q == COIN_LG) begin
            rem_d    = rem_q - LG_AMT;
            inv_lg_d = inv_lg_q - 1'b1;
          end else begin
            rem_d    = rem_q - SM_AMT;
            inv_sm_d = inv_sm_q - 1'b1;
          end
          state_d = ST_SELECT;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            state_d = ST_JAM;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_JAM: begin
        state_d = ST_JAM;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, coin, remaining amount and inventory registers.
  // NOTE: all of these are plain registers, not memories, so every one is
  // cleared by reset, including the inventory counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      coin_q   <= COIN_SM;
      rem_q    <= '0;
      inv_lg_q <= '0;
      inv_sm_q <= '0;
    end else begin
      state_q  <= state_d;
      coin_q   <= coin_d;
      rem_q    <= rem_d;
      inv_lg_q <= inv_lg_d;
      inv_sm_q <= inv_sm_d;
    end
  end

  // Outputs decode registered state only; req_ready also gates on refill.
  assign req_ready = (state_q == ST_IDLE) && !refill;
  assign busy      = (state_q != ST_IDLE);
  assign eject_lg  = (state_q == ST_EJECT) && (coin_q == COIN_LG);
  assign eject_sm  = (state_q == ST_EJECT) && (coin_q == COIN_SM);
  assign done      = (state_q == ST_DONE);
  assign short     = done && (rem_q != '0);
  assign unpaid    = done ? rem_q : '0;
  assign jam       = (state_q == ST_JAM);
  assign inv_lg    = inv_lg_q;
  assign inv_sm    = inv_sm_q;

endmodule
